coin_change_dispenser: RTL and testbench
========================================

Name: coin_change_dispenser

Overview:
- Outbound counterpart to the game's coin acceptor: pays credit back out as physical coin tokens (refund / change).
- Accepts a refund amount in credit units and dispenses it greedily, largest coin first, one coin per valid/taken handshake.
- Sits beside the coin acceptor in the top-level game. The game FSM issues the request. The coin-hopper model or testbench consumes the coins.
- Uses the same 2-bit coin encoding as the acceptor.

Parameters:
- AMT_W, 6: width of the refund amount and remaining-credit counters.
- VAL_CIRCLE, 1: credit value of coin code 2'b01.
- VAL_TRIANGLE, 3: credit value of coin code 2'b10.
- VAL_PENTAGON, 5: credit value of coin code 2'b11.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- RefundReq  in  1  start request; sampled only in IDLE.
- RefundAmt  in  AMT_W  credit to dispense; captured with RefundReq.
- CoinValid  out  1  a coin is being presented on CoinValue.
- CoinValue  out  2  coin code: 01 circle, 10 triangle, 11 pentagon; 00 when CoinValid=0.
- CoinTaken  in  1  consumer accepts the presented coin.
- Busy  out  1  high from the cycle after an accepted request until Done.
- Done  out  1  one-cycle pulse when the refund completes.
- Remaining  out  AMT_W  credit not yet dispensed.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. Ports are named clock and reset.
- Reset values: state=IDLE; CoinValid=0, CoinValue=00, Busy=0, Done=0, Remaining=0.
- States: IDLE, SELECT, PRESENT, FINISH.
- IDLE:
  - RefundReq=1 at an edge captures RefundAmt into Remaining.
  - If RefundAmt=0, go to FINISH; otherwise go to SELECT.
- SELECT (1 cycle):
  - Pick the largest coin with value <= Remaining: pentagon, then triangle, then circle.
  - Register the chosen code and go to PRESENT.
- PRESENT:
  - CoinValid=1 and CoinValue holds the chosen code. Both stay stable until CoinTaken is sampled high.
  - On the CoinTaken edge, Remaining -= coin value (never underflows, because the coin value <= Remaining).
  - If the new Remaining=0, go to FINISH; otherwise go to SELECT.
  - CoinValid drops for at least the SELECT cycle between coins.
- FINISH: Done=1 for exactly one cycle, Busy=0, then go to IDLE.
- Latency:
  - Request edge to first CoinValid is 2 cycles (SELECT then PRESENT).
  - Each further coin takes at least 2 cycles.
  - Last CoinTaken edge to Done is 1 cycle.
- Busy is 1 in SELECT and PRESENT only.
- RefundReq outside IDLE is ignored and not queued.
- CoinTaken outside PRESENT is ignored.
- RefundAmt at all-ones (63) must dispense correctly: 12 pentagons, 1 triangle.
- Reset mid-operation: CoinValid drops asynchronously and the pending refund is discarded. No Done pulse is produced.
- Simultaneous Done and a new RefundReq: the request is ignored because FINISH is not IDLE. The requester must re-assert.

Optional Feature:
- Macro: COIN_INVENTORY_EN.
- With the macro defined:
  - Adds inputs RestockEn (1), RestockCoin (2), RestockCnt (4).
  - Adds output Shortfall (1).
  - Keeps a 4-bit stock count per coin type. All counts reset to 0.
  - RestockEn sets the count of RestockCoin to RestockCnt, but only in IDLE.
  - SELECT skips any coin type whose count is 0. Each taken coin decrements its count.
  - If Remaining>0 and no usable coin exists, go to FINISH with Done=1 and Shortfall=1 for that cycle. Remaining keeps the unpaid amount until the next request.
- Without the macro: stock is unlimited, there are no extra ports, and Shortfall does not exist.

Test Plan:
- RefundAmt=9, CoinTaken tied 1 -> coins 11,10,01 on consecutive PRESENT cycles; Remaining 9→4→1→0; Done 1 cycle after the third take.
- RefundAmt=0 -> Done 1 cycle after the request; CoinValid never asserted; Busy stays 0.
- RefundAmt=5, CoinTaken held 0 for 4 cycles -> CoinValid=1 and CoinValue=11 stable for all 4 cycles; Remaining stays 5 until the take.
- RefundAmt=6 accepted; RefundReq with RefundAmt=3 during PRESENT -> ignored; output coins 11,01 only.
- RefundAmt=10; reset asserted during the second PRESENT -> CoinValid=0 immediately, Remaining=0, no Done; a new RefundAmt=1 afterwards gives a single 01 coin.
- COIN_INVENTORY_EN, stock pentagon=0, triangle=2, circle=0; RefundAmt=7 -> coins 10,10; Done=1 with Shortfall=1; Remaining=1.

Source files
------------

// File: rtl/coin_change_dispenser_if.sv
// Handshake bundle between the game FSM / coin hopper and coin_change_dispenser.
// The inventory signals exist only when COIN_INVENTORY_EN is defined.
interface coin_change_dispenser_if #(
  parameter int unsigned AMT_W = 6
);
  logic             RefundReq;
  logic [AMT_W-1:0] RefundAmt;
  logic             CoinValid;
  logic [1:0]       CoinValue;
  logic             CoinTaken;
  logic             Busy;
  logic             Done;
  logic [AMT_W-1:0] Remaining;
`ifdef COIN_INVENTORY_EN
  logic             RestockEn;
  logic [1:0]       RestockCoin;
  logic [3:0]       RestockCnt;
  logic             Shortfall;

  // Requester / coin consumer side
  modport master (
    output RefundReq, RefundAmt, CoinTaken, RestockEn, RestockCoin, RestockCnt,
    input  CoinValid, CoinValue, Busy, Done, Remaining, Shortfall
  );

  // Dispenser side
  modport slave (
    input  RefundReq, RefundAmt, CoinTaken, RestockEn, RestockCoin, RestockCnt,
    output CoinValid, CoinValue, Busy, Done, Remaining, Shortfall
  );
`else
  // Requester / coin consumer side
  modport master (
    output RefundReq, RefundAmt, CoinTaken,
    input  CoinValid, CoinValue, Busy, Done, Remaining
  );

  // Dispenser side
  modport slave (
    input  RefundReq, RefundAmt, CoinTaken,
    output CoinValid, CoinValue, Busy, Done, Remaining
  );
`endif
endinterface

// File: rtl/coin_change_dispenser.sv
// Coin change dispenser: pays a refund amount out greedily (largest coin first),
// one coin per CoinValid/CoinTaken handshake.
// Coin codes: 01 circle, 10 triangle, 11 pentagon.
// Optional macro COIN_INVENTORY_EN adds per-coin 4-bit stock counts, restocking
// and a Shortfall flag when the remaining credit cannot be paid from stock.
module coin_change_dispenser #(
  parameter int unsigned AMT_W        = 6,
  parameter int unsigned VAL_CIRCLE   = 1,
  parameter int unsigned VAL_TRIANGLE = 3,
  parameter int unsigned VAL_PENTAGON = 5
) (
  input logic                    clock,
  input logic                    reset,
  coin_change_dispenser_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SELECT  = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;
  localparam logic [1:0] ST_FINISH  = 2'd3;

  localparam logic [AMT_W-1:0] AMT_CIRCLE   = AMT_W'(VAL_CIRCLE);
  localparam logic [AMT_W-1:0] AMT_TRIANGLE = AMT_W'(VAL_TRIANGLE);
  localparam logic [AMT_W-1:0] AMT_PENTAGON = AMT_W'(VAL_PENTAGON);

  logic [1:0]       state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [1:0]       coin_q, coin_d;
  logic [AMT_W-1:0] coin_val;
  logic [AMT_W-1:0] remaining_after;
  logic             has_circle, has_triangle, has_pentagon;
  logic             pick_ok;
  logic [1:0]       pick_code;
  logic             take;

  assign take            = (state_q == ST_PRESENT) && bus.CoinTaken;
  assign remaining_after = remaining_q - coin_val;

`ifdef COIN_INVENTORY_EN
  logic [3:0] stock_c_q, stock_t_q, stock_p_q;
  logic       short_q;

  assign has_circle   = (stock_c_q != 4'd0);
  assign has_triangle = (stock_t_q != 4'd0);
  assign has_pentagon = (stock_p_q != 4'd0);

  // Stock counts: restock only while idle, decrement on every taken coin
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stock_c_q <= 4'd0;
      stock_t_q <= 4'd0;
      stock_p_q <= 4'd0;
    end else if (state_q == ST_IDLE && bus.RestockEn) begin
      case (bus.RestockCoin)
        2'b01:   stock_c_q <= bus.RestockCnt;
        2'b10:   stock_t_q <= bus.RestockCnt;
        2'b11:   stock_p_q <= bus.RestockCnt;
        default: ;
      endcase
    end else if (take) begin
      case (coin_q)
        2'b01:   stock_c_q <= stock_c_q - 4'd1;
        2'b10:   stock_t_q <= stock_t_q - 4'd1;
        2'b11:   stock_p_q <= stock_p_q - 4'd1;
        default: ;
      endcase
    end
  end

  // Shortfall flag: set when SELECT finds no usable coin, cleared after FINISH
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      short_q <= 1'b0;
    end else if (state_q == ST_SELECT && !pick_ok) begin
      short_q <= 1'b1;
    end else if (state_q == ST_FINISH) begin
      short_q <= 1'b0;
    end
  end

  assign bus.Shortfall = (state_q == ST_FINISH) && short_q;
`else
  // Unlimited stock
  assign has_circle   = 1'b1;
  assign has_triangle = 1'b1;
  assign has_pentagon = 1'b1;
`endif

  // Credit value of the currently held coin
  always_comb begin
    coin_val = AMT_CIRCLE;
    unique case (coin_q)
      2'b11:   coin_val = AMT_PENTAGON;
      2'b10:   coin_val = AMT_TRIANGLE;
      default: coin_val = AMT_CIRCLE;
    endcase
  end

  // Greedy choice: largest available coin that still fits the remaining credit
  always_comb begin
    pick_ok   = 1'b1;
    pick_code = 2'b01;
    if (has_pentagon && remaining_q >= AMT_PENTAGON) begin
      pick_code = 2'b11;
    end else if (has_triangle && remaining_q >= AMT_TRIANGLE) begin
      pick_code = 2'b10;
    end else if (has_circle && remaining_q >= AMT_CIRCLE) begin
      pick_code = 2'b01;
    end else begin
      pick_ok = 1'b0;
    end
  end

  // Next-state logic for the dispense sequence
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    coin_d      = coin_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.RefundReq) begin
          remaining_d = bus.RefundAmt;
          state_d     = (bus.RefundAmt == '0) ? ST_FINISH : ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (pick_ok) begin
          coin_d  = pick_code;
          state_d = ST_PRESENT;
        end else begin
          // Out of usable stock: unpaid credit stays in Remaining
          state_d = ST_FINISH;
        end
      end
      ST_PRESENT: begin
        if (bus.CoinTaken) begin
          remaining_d = remaining_after;
          state_d     = (remaining_after == '0) ? ST_FINISH : ST_SELECT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; async reset discards any pending refund
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      coin_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      coin_q      <= coin_d;
    end
  end

  // Outputs decode directly from state so reset drops CoinValid immediately
  always_comb begin
    bus.CoinValid = (state_q == ST_PRESENT);
    bus.CoinValue = (state_q == ST_PRESENT) ? coin_q : 2'b00;
    bus.Busy      = (state_q == ST_SELECT) || (state_q == ST_PRESENT);
    bus.Done      = (state_q == ST_FINISH);
    bus.Remaining = remaining_q;
  end

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Scoreboard bench for coin_change_dispenser: stimulus pushes expected coin and
// done events into a queue; a monitor pops and compares on every handshake/Done.
module tb_coin_change_dispenser;

  typedef struct {
    bit         is_done;
    logic [1:0] code;
    logic [5:0] rem;
    bit         short_f;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  ev_t  exp_q[$];

  coin_change_dispenser_if #(.AMT_W(6)) bus ();

  coin_change_dispenser dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit d, input logic [1:0] c, input logic [5:0] r, input bit s);
    ev_t e;
    e.is_done = d;
    e.code    = c;
    e.rem     = r;
    e.short_f = s;
    exp_q.push_back(e);
  endtask

  task automatic observe(input bit d, input logic [1:0] c, input logic [5:0] r, input bit s);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got done=%0b code=%0b rem=%0d, expected none at %0t",
               d, c, r, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.is_done != d || r !== e.rem || (!d && c !== e.code)
`ifdef COIN_INVENTORY_EN
          || (d && s !== e.short_f)
`endif
         ) begin
        errors++;
        $display("FAIL event: got done=%0b code=%0b rem=%0d short=%0b expected done=%0b code=%0b rem=%0d short=%0b at %0t",
                 d, c, r, s, e.is_done, e.code, e.rem, e.short_f, $time);
      end
    end
  endtask

  // Monitor: one event per coin handshake, one per Done pulse
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.CoinValid && bus.CoinTaken) observe(1'b0, bus.CoinValue, bus.Remaining, 1'b0);
`ifdef COIN_INVENTORY_EN
      if (bus.Done) observe(1'b1, 2'b00, bus.Remaining, bus.Shortfall);
`else
      if (bus.Done) observe(1'b1, 2'b00, bus.Remaining, 1'b0);
`endif
    end
  end

  task automatic request(input logic [5:0] amt);
    @(posedge clock); #1;
    bus.RefundReq = 1'b1;
    bus.RefundAmt = amt;
    @(posedge clock); #1;
    bus.RefundReq = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (bus.Done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: got no Done, expected Done within %0d cycles", budget);
    end
    @(posedge clock); #1;
  endtask

  task automatic restock(input logic [1:0] code, input logic [3:0] cnt);
`ifdef COIN_INVENTORY_EN
    @(posedge clock); #1;
    bus.RestockEn   = 1'b1;
    bus.RestockCoin = code;
    bus.RestockCnt  = cnt;
    @(posedge clock); #1;
    bus.RestockEn   = 1'b0;
`else
    if (code == 2'b00 && cnt == 4'd0) @(posedge clock);
`endif
  endtask

  task automatic stock_all();
    restock(2'b01, 4'd15);
    restock(2'b10, 4'd15);
    restock(2'b11, 4'd15);
  endtask

  initial begin
    bus.RefundReq = 1'b0;
    bus.RefundAmt = '0;
    bus.CoinTaken = 1'b0;
`ifdef COIN_INVENTORY_EN
    bus.RestockEn   = 1'b0;
    bus.RestockCoin = 2'b00;
    bus.RestockCnt  = 4'd0;
`endif

    // Reset state
    @(negedge clock);
    chk("rst_valid", bus.CoinValid, 0);
    chk("rst_value", bus.CoinValue, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_done", bus.Done, 0);
    chk("rst_remaining", bus.Remaining, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // 9 = pentagon + triangle + circle, take tied high
    stock_all();
    bus.CoinTaken = 1'b1;
    push(0, 2'b11, 9, 0);
    push(0, 2'b10, 4, 0);
    push(0, 2'b01, 1, 0);
    push(1, 2'b00, 0, 0);
    request(6'd9);
    @(negedge clock);
    chk("t9_select_valid", bus.CoinValid, 0);
    chk("t9_select_busy", bus.Busy, 1);
    @(negedge clock);
    chk("t9_first_valid", bus.CoinValid, 1);
    chk("t9_first_value", bus.CoinValue, 2'b11);
    @(negedge clock);
    chk("t9_gap_valid", bus.CoinValid, 0);
    @(negedge clock);
    chk("t9_second_value", bus.CoinValue, 2'b10);
    @(negedge clock);
    @(negedge clock);
    chk("t9_third_value", bus.CoinValue, 2'b01);
    @(negedge clock);
    chk("t9_done_latency", bus.Done, 1);
    chk("t9_done_busy", bus.Busy, 0);
    @(posedge clock); #1;

    // Zero amount: straight to Done, no coins, never busy
    push(1, 2'b00, 0, 0);
    request(6'd0);
    @(negedge clock);
    chk("t0_done", bus.Done, 1);
    chk("t0_busy", bus.Busy, 0);
    chk("t0_valid", bus.CoinValid, 0);
    @(posedge clock); #1;

    // Stalled consumer: coin and Remaining hold until taken
    stock_all();
    bus.CoinTaken = 1'b0;
    push(0, 2'b11, 5, 0);
    push(1, 2'b00, 0, 0);
    request(6'd5);
    @(posedge clock);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("t5_hold_valid", bus.CoinValid, 1);
      chk("t5_hold_value", bus.CoinValue, 2'b11);
      chk("t5_hold_remaining", bus.Remaining, 5);
    end
    @(posedge clock); #1;
    bus.CoinTaken = 1'b1;
    wait_done(20);

    // Request during PRESENT is ignored
    stock_all();
    push(0, 2'b11, 6, 0);
    push(0, 2'b01, 1, 0);
    push(1, 2'b00, 0, 0);
    request(6'd6);
    @(posedge clock); #1;
    bus.RefundReq = 1'b1;
    bus.RefundAmt = 6'd3;
    @(posedge clock); #1;
    @(posedge clock); #1;
    bus.RefundReq = 1'b0;
    wait_done(20);
    @(negedge clock);
    chk("t6_not_queued_busy", bus.Busy, 0);
    chk("t6_not_queued_valid", bus.CoinValid, 0);

    // Largest amount: 12 pentagons then a triangle
    stock_all();
    for (int k = 0; k < 12; k++) push(0, 2'b11, 6'(63 - 5 * k), 0);
    push(0, 2'b10, 3, 0);
    push(1, 2'b00, 0, 0);
    request(6'd63);
    wait_done(100);

    // Reset during the second PRESENT discards the refund
    stock_all();
    push(0, 2'b11, 10, 0);
    request(6'd10);
    @(posedge clock); #1;
    @(posedge clock); #1;
    bus.CoinTaken = 1'b0;
    @(posedge clock); #2;
    chk("t10_second_present", bus.CoinValid, 1);
    reset = 1'b1;
    #1;
    chk("t10_rst_valid", bus.CoinValid, 0);
    chk("t10_rst_value", bus.CoinValue, 0);
    chk("t10_rst_remaining", bus.Remaining, 0);
    chk("t10_rst_busy", bus.Busy, 0);
    @(negedge clock);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("t10_no_done", bus.Done, 0);
    stock_all();
    bus.CoinTaken = 1'b1;
    push(0, 2'b01, 1, 0);
    push(1, 2'b00, 0, 0);
    request(6'd1);
    wait_done(20);

`ifdef COIN_INVENTORY_EN
    // Limited stock: two triangles only, one credit left unpaid
    restock(2'b11, 4'd0);
    restock(2'b10, 4'd2);
    restock(2'b01, 4'd0);
    push(0, 2'b10, 7, 0);
    push(0, 2'b10, 4, 0);
    push(1, 2'b00, 1, 1);
    request(6'd7);
    wait_done(30);
    @(negedge clock);
    chk("inv_remaining_kept", bus.Remaining, 1);
    chk("inv_short_cleared", bus.Shortfall, 0);
`endif

    repeat (3) @(negedge clock);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
